test_sequencer: RTL and testbench
=================================

TEST_SEQUENCER -- requirements
Module: test_sequencer

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 4, the maximum number of blocks sent to the chip but not yet answered (1..15).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 200000, the number of clk cycles without progress before a timeout.
REQ-003 SHALL have port clk  input  1  single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that starts a test run.
REQ-006 SHALL have port abort  input  1  one-cycle pulse that stops a run.
REQ-007 SHALL have port num_vectors  input  32  blocks per run, sampled on an accepted start.
REQ-008 SHALL have port blk_sent  input  1  one-cycle pulse, one block fully transmitted to the chip.
REQ-009 SHALL have port rx_done  input  1  one-cycle pulse, one chip result received.
REQ-010 SHALL have port rx_ok  input  1  scoreboard compare result, valid only when rx_done=1.
REQ-011 SHALL have port work  output  1  enables the data generator to produce the next block.
REQ-012 SHALL have port busy  output  1  high in RUN or DRAIN.
REQ-013 SHALL have port done  output  1  high in DONE.
REQ-014 SHALL have port pass  output  1  high in DONE when err_cnt=0.
REQ-015 SHALL have port timeout_err  output  1  high in ERROR.
REQ-016 SHALL have port spurious  output  1  sticky flag: an rx_done arrived while inflight=0.
REQ-017 SHALL have ports sent_cnt, recv_cnt, err_cnt  output  32 each  run counters.

Function
REQ-018 SHALL implement an FSM with states IDLE, RUN, DRAIN, DONE, ERROR.
REQ-019 SHALL define inflight = sent_cnt - recv_cnt, computed modulo 2^32.
REQ-020 In IDLE, DONE or ERROR, a start SHALL latch num_vectors as target, clear all counters and spurious, and go to RUN; if num_vectors=0 it SHALL go to DONE instead, with pass=1.
REQ-021 start SHALL be ignored in RUN and DRAIN.
REQ-022 work SHALL be a combinational decode, high only when state=RUN, sent_cnt<target and inflight<MAX_INFLIGHT.
REQ-023 blk_sent SHALL increment sent_cnt only in RUN with sent_cnt<target; it SHALL be ignored otherwise.
REQ-024 rx_done SHALL increment recv_cnt only in RUN or DRAIN with inflight>0; err_cnt SHALL increment in the same cycle if rx_ok=0.
REQ-025 rx_done with inflight=0 SHALL set spurious and leave all counters unchanged.
REQ-026 blk_sent and rx_done in the same cycle SHALL both be counted; inflight stays unchanged.
REQ-027 RUN SHALL go to DRAIN on the edge where sent_cnt reaches target.
REQ-028 DRAIN SHALL go to DONE on the edge where recv_cnt reaches target.
REQ-029 A watchdog counter SHALL clear on any counted blk_sent or rx_done, and on entry to RUN.
REQ-030 The watchdog SHALL increment in RUN and DRAIN while inflight>0.
REQ-031 When the watchdog reaches TIMEOUT_CYC-1 with no progress event, the FSM SHALL go to ERROR on the next edge.
REQ-032 abort in RUN or DRAIN SHALL return to IDLE; counters SHALL hold their values and work SHALL be low the same cycle the state is IDLE.
REQ-033 abort in ERROR SHALL return to IDLE; abort in IDLE or DONE SHALL be ignored.
REQ-034 start and abort asserted in the same cycle SHALL resolve with abort taking priority.
REQ-035 A progress event in the same cycle the watchdog expires SHALL take priority and clear the watchdog.
REQ-036 Counters SHALL saturate at 2^32-1 and never wrap.
REQ-037 done, pass, timeout_err and busy SHALL be registered decodes of the state.

Reset
REQ-038 While rst_n=0, the FSM SHALL be in IDLE, all counters, target and the watchdog SHALL be 0, and all 1-bit outputs SHALL be 0, applied asynchronously.
REQ-039 Reset asserted mid-run SHALL abandon the run; after reset release no run starts until a new start pulse.

Verification
REQ-040 num_vectors=10, MAX_INFLIGHT=4, the chip answers each block 20 cycles after blk_sent with rx_ok=1 -> work never high with inflight=4, DONE reached, sent_cnt=recv_cnt=10, err_cnt=0, pass=1.
REQ-041 num_vectors=5, rx_ok=0 on the 3rd result -> DONE reached, err_cnt=1, pass=0.
REQ-042 TIMEOUT_CYC=50, num_vectors=3, the chip never answers -> ERROR entered exactly 50 cycles after the last blk_sent, timeout_err=1, work=0.
REQ-043 rx_done pulsed in IDLE, then a run started and abort pulsed mid-RUN -> spurious=1 before the start and 0 after it; IDLE reached the cycle after abort with counters held.
REQ-044 blk_sent and rx_done pulsed in the same cycle at inflight=2 -> both counters +1, inflight stays 2.
REQ-045 start with num_vectors=0 -> DONE on the next edge, pass=1, work never asserted.

Source files
------------

// File: rtl/test_sequencer.sv
// test_sequencer: run controller for a chip test. It paces the data generator
// with a credit window of MAX_INFLIGHT unanswered blocks, counts sent blocks,
// received results and compare errors, and guards the run with a no-progress
// watchdog that ends the run in ERROR when the chip stops responding.
module test_sequencer #(
    parameter int MAX_INFLIGHT = 4,       // 1..15 blocks sent but not yet answered
    parameter int TIMEOUT_CYC  = 200000   // cycles without progress before ERROR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [31:0] num_vectors,
    input  logic        blk_sent,
    input  logic        rx_done,
    input  logic        rx_ok,
    output logic        work,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_err,
    output logic        spurious,
    output logic [31:0] sent_cnt,
    output logic [31:0] recv_cnt,
    output logic [31:0] err_cnt
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_e;

    localparam logic [31:0] CNT_MAX      = 32'hFFFF_FFFF;
    localparam logic [31:0] WDOG_LAST    = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] INFLIGHT_MAX = 32'(MAX_INFLIGHT);

    state_e      state_q, state_d;
    logic [31:0] target_q, target_d;
    logic [31:0] sent_q, sent_d;
    logic [31:0] recv_q, recv_d;
    logic [31:0] err_q, err_d;
    logic [31:0] wdog_q, wdog_d;
    logic        spurious_q, spurious_d;
    logic        busy_q, done_q, pass_q, timeout_q;

    logic [31:0] inflight;
    logic        in_run;
    logic        in_busy;
    logic        sent_evt;
    logic        recv_evt;
    logic        progress;

    // Saturating increment: run counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == CNT_MAX) ? v : v + 32'd1;
    endfunction

    // Blocks outstanding at the chip; modulo-2^32 difference of the counters.
    assign inflight = sent_q - recv_q;
    assign in_run   = (state_q == ST_RUN);
    assign in_busy  = (state_q == ST_RUN) || (state_q == ST_DRAIN);

    // Qualified progress events: only these move counters or feed the watchdog.
    assign sent_evt = in_run  && blk_sent && (sent_q < target_q);
    assign recv_evt = in_busy && rx_done  && (inflight != 32'd0);
    assign progress = sent_evt || recv_evt;

    // Next-state logic: abort outranks start, progress outranks watchdog expiry.
    always_comb begin
        // NOTE: every variable gets a default before any branch; a path that
        // skips an assignment would otherwise infer a latch.
        state_d    = state_q;
        target_d   = target_q;
        sent_d     = sent_q;
        recv_d     = recv_q;
        err_d      = err_q;
        wdog_d     = wdog_q;
        spurious_d = spurious_q;

        // A result with nothing outstanding is flagged but never counted.
        if (rx_done && (inflight == 32'd0)) begin
            spurious_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (abort) begin
                    // Abort only leaves ERROR; it also swallows a concurrent start.
                    if (state_q == ST_ERROR) begin
                        state_d = ST_IDLE;
                    end
                end else if (start) begin
                    target_d   = num_vectors;
                    sent_d     = 32'd0;
                    recv_d     = 32'd0;
                    err_d      = 32'd0;
                    wdog_d     = 32'd0;
                    spurious_d = 1'b0;
                    state_d    = (num_vectors == 32'd0) ? ST_DONE : ST_RUN;
                end
            end

            ST_RUN, ST_DRAIN: begin
                if (abort) begin
                    // Counters freeze so software can inspect the partial run.
                    state_d = ST_IDLE;
                end else begin
                    if (sent_evt) begin
                        sent_d = sat_inc(sent_q);
                    end
                    if (recv_evt) begin
                        recv_d = sat_inc(recv_q);
                        if (!rx_ok) begin
                            err_d = sat_inc(err_q);
                        end
                    end

                    // Watchdog only runs while the chip owes us results.
                    if (progress) begin
                        wdog_d = 32'd0;
                    end else if ((inflight != 32'd0) && (wdog_q != CNT_MAX)) begin
                        wdog_d = wdog_q + 32'd1;
                    end

                    if (in_run && (sent_d == target_q)) begin
                        state_d = ST_DRAIN;
                    end else if (!in_run && (recv_d == target_q)) begin
                        state_d = ST_DONE;
                    end else if (!progress && (wdog_q == WDOG_LAST)) begin
                        state_d = ST_ERROR;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State, target, counters, watchdog and sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            target_q   <= 32'd0;
            sent_q     <= 32'd0;
            recv_q     <= 32'd0;
            err_q      <= 32'd0;
            wdog_q     <= 32'd0;
            spurious_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep all registers sampling the
            // pre-edge values; blocking here would create ordering races.
            state_q    <= state_d;
            target_q   <= target_d;
            sent_q     <= sent_d;
            recv_q     <= recv_d;
            err_q      <= err_d;
            wdog_q     <= wdog_d;
            spurious_q <= spurious_d;
        end
    end

    // Registered state decodes, taken from the next state so they line up
    // with the state register rather than lagging it by a cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            busy_q    <= (state_d == ST_RUN) || (state_d == ST_DRAIN);
            done_q    <= (state_d == ST_DONE);
            pass_q    <= (state_d == ST_DONE) && (err_d == 32'd0);
            timeout_q <= (state_d == ST_ERROR);
        end
    end

    // Generator enable: combinational so it drops in the same cycle the
    // credit window fills or the state leaves RUN.
    assign work = in_run && (sent_q < target_q) && (inflight < INFLIGHT_MAX);

    assign busy        = busy_q;
    assign done        = done_q;
    assign pass        = pass_q;
    assign timeout_err = timeout_q;
    assign spurious    = spurious_q;
    assign sent_cnt    = sent_q;
    assign recv_cnt    = recv_q;
    assign err_cnt     = err_q;

endmodule

// File: tb/tb_test_sequencer.sv
// tb_test_sequencer: table of single-cycle vectors for counting, spurious,
// abort and start corner cases, then hand-written runs with a chip model for
// flow control, error counting, watchdog timeout and reset mid-run.
module tb_test_sequencer;

    localparam int MAX_INF = 4;
    localparam int TO_CYC  = 50;
    localparam int LAT     = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] num_vectors = 32'd0;
    logic        blk_sent = 1'b0;
    logic        rx_done = 1'b0;
    logic        rx_ok = 1'b0;
    logic        work, busy, done, pass, timeout_err, spurious;
    logic [31:0] sent_cnt, recv_cnt, err_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    test_sequencer #(.MAX_INFLIGHT(MAX_INF), .TIMEOUT_CYC(TO_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .num_vectors(num_vectors),
        .blk_sent   (blk_sent),
        .rx_done    (rx_done),
        .rx_ok      (rx_ok),
        .work       (work),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .timeout_err(timeout_err),
        .spurious   (spurious),
        .sent_cnt   (sent_cnt),
        .recv_cnt   (recv_cnt),
        .err_cnt    (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st, ab;
        logic [31:0] nv;
        logic        bs, rd, ok;
        logic        w, b, d, p, t, s;
        logic [31:0] sc, rc, ec;
    } vec_t;

    vec_t vecs[27];

    function automatic vec_t mk(input logic st, ab, input logic [31:0] nv,
                                input logic bs, rd, ok,
                                input logic w, b, d, p, t, s,
                                input logic [31:0] sc, rc, ec);
        vec_t v;
        v.st = st; v.ab = ab; v.nv = nv; v.bs = bs; v.rd = rd; v.ok = ok;
        v.w = w; v.b = b; v.d = d; v.p = p; v.t = t; v.s = s;
        v.sc = sc; v.rc = rc; v.ec = ec;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, return just after the rising edge.
    task automatic apply(input logic st, ab, input logic [31:0] nv, input logic bs, rd, ok);
        @(negedge clk);
        start = st; abort = ab; num_vectors = nv;
        blk_sent = bs; rx_done = rd; rx_ok = ok;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Start a run and play a chip that answers every block LAT cycles after it
    // was sent; result number bad_idx (1-based) fails compare.
    task automatic run_chip(input logic [31:0] nv, input int bad_idx, output int over);
        int due[$];
        int c, nres, infl;
        logic bs, rd, ok;
        apply(1'b1, 1'b0, nv, 1'b0, 1'b0, 1'b0);
        c = 0; nres = 0; infl = 0; over = 0;
        while (!done && c < 2000) begin
            bs = work;
            if (work && infl >= MAX_INF) over++;
            rd = 1'b0; ok = 1'b0;
            if (due.size() > 0 && due[0] == c) begin
                void'(due.pop_front());
                rd = 1'b1;
                nres++;
                ok = (nres != bad_idx);
            end
            apply(1'b0, 1'b0, 32'd0, bs, rd, ok);
            if (bs) begin
                due.push_back(c + LAT);
                infl++;
            end
            if (rd) infl--;
            c++;
        end
        check("run_reached_done", {31'd0, done}, 32'd1);
    endtask

    initial begin
        int over, k, g;

        //            st ab nv  bs rd ok   w  b  d  p  t  s   sent recv err
        vecs[0]  = mk(0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  0, 0, 0);
        vecs[1]  = mk(0, 0, 0,  0, 1, 1,   0, 0, 0, 0, 0, 1,  0, 0, 0);
        vecs[2]  = mk(0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 1,  0, 0, 0);
        vecs[3]  = mk(1, 0, 0,  0, 0, 0,   0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[4]  = mk(0, 1, 0,  0, 0, 0,   0, 0, 1, 1, 0, 0,  0, 0, 0);
        vecs[5]  = mk(1, 0, 6,  0, 0, 0,   1, 1, 0, 0, 0, 0,  0, 0, 0);
        vecs[6]  = mk(1, 0, 2,  1, 0, 0,   1, 1, 0, 0, 0, 0,  1, 0, 0);
        vecs[7]  = mk(0, 0, 0,  1, 0, 0,   1, 1, 0, 0, 0, 0,  2, 0, 0);
        vecs[8]  = mk(0, 0, 0,  1, 1, 1,   1, 1, 0, 0, 0, 0,  3, 1, 0);
        vecs[9]  = mk(0, 0, 0,  0, 1, 0,   1, 1, 0, 0, 0, 0,  3, 2, 1);
        vecs[10] = mk(0, 0, 0,  0, 1, 1,   1, 1, 0, 0, 0, 0,  3, 3, 1);
        vecs[11] = mk(0, 0, 0,  0, 1, 1,   1, 1, 0, 0, 0, 1,  3, 3, 1);
        vecs[12] = mk(0, 0, 0,  1, 0, 0,   1, 1, 0, 0, 0, 1,  4, 3, 1);
        vecs[13] = mk(0, 0, 0,  1, 0, 0,   1, 1, 0, 0, 0, 1,  5, 3, 1);
        vecs[14] = mk(1, 1, 9,  0, 0, 0,   0, 0, 0, 0, 0, 1,  5, 3, 1);
        vecs[15] = mk(0, 0, 0,  1, 0, 0,   0, 0, 0, 0, 0, 1,  5, 3, 1);
        vecs[16] = mk(1, 0, 1,  0, 0, 0,   1, 1, 0, 0, 0, 0,  0, 0, 0);
        vecs[17] = mk(0, 0, 0,  1, 0, 0,   0, 1, 0, 0, 0, 0,  1, 0, 0);
        vecs[18] = mk(0, 0, 0,  1, 0, 0,   0, 1, 0, 0, 0, 0,  1, 0, 0);
        vecs[19] = mk(0, 0, 0,  0, 1, 1,   0, 0, 1, 1, 0, 0,  1, 1, 0);
        vecs[20] = mk(1, 0, 6,  0, 0, 0,   1, 1, 0, 0, 0, 0,  0, 0, 0);
        vecs[21] = mk(0, 0, 0,  1, 0, 0,   1, 1, 0, 0, 0, 0,  1, 0, 0);
        vecs[22] = mk(0, 0, 0,  1, 0, 0,   1, 1, 0, 0, 0, 0,  2, 0, 0);
        vecs[23] = mk(0, 0, 0,  1, 0, 0,   1, 1, 0, 0, 0, 0,  3, 0, 0);
        vecs[24] = mk(0, 0, 0,  1, 0, 0,   0, 1, 0, 0, 0, 0,  4, 0, 0);
        vecs[25] = mk(0, 0, 0,  0, 1, 1,   1, 1, 0, 0, 0, 0,  4, 1, 0);
        vecs[26] = mk(0, 1, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0,  4, 1, 0);

        // Reset state, held across clock edges.
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pass", {31'd0, pass}, 32'd0);
        check("rst_timeout", {31'd0, timeout_err}, 32'd0);
        check("rst_spurious", {31'd0, spurious}, 32'd0);
        check("rst_work", {31'd0, work}, 32'd0);
        check("rst_sent", sent_cnt, 32'd0);
        check("rst_recv", recv_cnt, 32'd0);
        check("rst_err", err_cnt, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 27; i++) begin
            apply(vecs[i].st, vecs[i].ab, vecs[i].nv, vecs[i].bs, vecs[i].rd, vecs[i].ok);
            check($sformatf("v%0d.work", i), {31'd0, work}, {31'd0, vecs[i].w});
            check($sformatf("v%0d.busy", i), {31'd0, busy}, {31'd0, vecs[i].b});
            check($sformatf("v%0d.done", i), {31'd0, done}, {31'd0, vecs[i].d});
            check($sformatf("v%0d.pass", i), {31'd0, pass}, {31'd0, vecs[i].p});
            check($sformatf("v%0d.timeout", i), {31'd0, timeout_err}, {31'd0, vecs[i].t});
            check($sformatf("v%0d.spurious", i), {31'd0, spurious}, {31'd0, vecs[i].s});
            check($sformatf("v%0d.sent", i), sent_cnt, vecs[i].sc);
            check($sformatf("v%0d.recv", i), recv_cnt, vecs[i].rc);
            check($sformatf("v%0d.err", i), err_cnt, vecs[i].ec);
        end
        idle();

        // Ten blocks with a 20-cycle chip: credit window respected, clean pass.
        run_chip(32'd10, 0, over);
        check("r10_window_overrun", over, 32'd0);
        check("r10_sent", sent_cnt, 32'd10);
        check("r10_recv", recv_cnt, 32'd10);
        check("r10_err", err_cnt, 32'd0);
        check("r10_pass", {31'd0, pass}, 32'd1);
        check("r10_busy", {31'd0, busy}, 32'd0);
        idle();

        // Five blocks, third result fails compare.
        run_chip(32'd5, 3, over);
        check("r5_sent", sent_cnt, 32'd5);
        check("r5_recv", recv_cnt, 32'd5);
        check("r5_err", err_cnt, 32'd1);
        check("r5_pass", {31'd0, pass}, 32'd0);
        idle();

        // Chip never answers: ERROR exactly TO_CYC cycles after the last block.
        apply(1'b1, 1'b0, 32'd3, 1'b0, 1'b0, 1'b0);
        g = 0;
        while (sent_cnt < 32'd3 && g < 20) begin
            apply(1'b0, 1'b0, 32'd0, work, 1'b0, 1'b0);
            g++;
        end
        check("to_sent", sent_cnt, 32'd3);
        k = 0;
        while (!timeout_err && k < 200) begin
            idle();
            k++;
        end
        check("to_latency", k, TO_CYC);
        check("to_flag", {31'd0, timeout_err}, 32'd1);
        check("to_work", {31'd0, work}, 32'd0);
        check("to_busy", {31'd0, busy}, 32'd0);
        idle();
        check("to_flag_sticks", {31'd0, timeout_err}, 32'd1);
        apply(1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);
        check("to_abort_clears", {31'd0, timeout_err}, 32'd0);
        check("to_abort_held_sent", sent_cnt, 32'd3);

        // Reset in the middle of a run clears everything asynchronously.
        apply(1'b1, 1'b0, 32'd5, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
        check("mr_sent_before", sent_cnt, 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("mr_async_sent", sent_cnt, 32'd0);
        check("mr_async_busy", {31'd0, busy}, 32'd0);
        check("mr_async_work", {31'd0, work}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) idle();
        check("mr_after_busy", {31'd0, busy}, 32'd0);
        check("mr_after_done", {31'd0, done}, 32'd0);
        check("mr_after_sent", sent_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
